sipo_jk_deser: RTL
==================

// Module: sipo_jk_deser
// PURPOSE
//  Serial-in parallel-out deserializer. Consumes the 1-bit stream from the
//  upstream 4-bit PISO shifter, which sends MSB first, and rebuilds WIDTH-bit words.
//  Each completed word goes into an output holding register and is offered
//  downstream through a valid/ready handshake. Overruns set a sticky flag.
// PARAMETERS
//  WIDTH   4   bits per word; legal range 2..32
//  CNT_W   $clog2(WIDTH+1)   width of the bit counter
// PORTS
//  clk      in   1        rising-edge clock
//  res      in   1        asynchronous reset, active-low (0 = reset)
//  si       in   1        serial data in; MSB of each word arrives first
//  si_en    in   1        sample si on this clk edge
//  flush    in   1        synchronous: discard the partial word, bit count to 0
//  dout     out  WIDTH    parallel word in the holding register
//  dout_vld out  1        holding register contains an unconsumed word
//  dout_rdy in   1        downstream accepts dout when dout_vld & dout_rdy
//  bit_cnt  out  CNT_W    bits collected in the current partial word
//  ovr      out  1        sticky overrun flag
//  ovr_clr  in   1        synchronous clear of ovr
// BEHAVIOUR
//  - Reset (res=0, async): shift reg, dout, bit_cnt, dout_vld and ovr all
//    return to 0 immediately. Reset mid-word drops the partial word.
//  - Shift: when si_en=1 and flush=0, sreg <= {sreg[WIDTH-2:0], si} and
//    bit_cnt increments. si_en=0: shift register and counter hold.
//  - Completion: occurs on the edge that samples bit WIDTH (bit_cnt==WIDTH-1 & si_en).
//    On that edge bit_cnt wraps to 0 and the word {sreg[WIDTH-2:0],si} is the candidate.
//  - Transfer: the candidate loads dout and dout_vld=1 on that same edge when
//    the holding register is free: dout_vld=0, or dout_vld&dout_rdy this cycle.
//    Latency: last bit sampled at edge N -> dout/dout_vld visible after edge N.
//  - Handshake: dout is stable while dout_vld=1 and dout_rdy=0.
//    When dout_vld&dout_rdy, dout_vld clears on the next edge, unless a new word
//    completes in the same cycle. Then dout reloads and dout_vld stays 1,
//    so back-to-back words need no idle cycle.
//  - Overrun: completion while dout_vld=1 & dout_rdy=0 -> the new word is dropped,
//    dout is unchanged and ovr <= 1.
//    ovr stays set until ovr_clr=1. If set and clear fall on the same edge, set wins.
//  - flush=1: bit_cnt <= 0 and any si_en bit that cycle is discarded (flush
//    wins). Flush does not touch dout, dout_vld or ovr.
//  - Next word: the counter wraps, so bit 1 of the next word can be sampled
//    on the edge right after completion. No gap is required.
//  - Implementation: one JK flip-flop per state bit, driven J=D, K=~D, matching
//    the upstream shifter. Counter and control logic are behavioural.
// TESTING (WIDTH=4)
//  1. res=0 with si_en toggling -> all outputs 0. After release, bit_cnt=0.
//  2. Drive 1,0,1,1 with si_en=1, dout_rdy=1 -> dout=4'b1011 and
//     dout_vld=1 right after the 4th edge. It drops one cycle later.
//  3. Upstream PISO loads 4'hA then 4'h5, serial back-to-back, dout_rdy=1 ->
//     dout=4'hA then 4'h5 exactly 4 edges apart, ovr=0.
//  4. dout_rdy=0, send 4'h3 then 4'hC -> dout holds 4'h3, ovr=1.
//     Then dout_rdy=1 -> 4'h3 is consumed. ovr_clr=1 -> ovr=0.
//  5. Send 2 bits, then flush=1 with si_en=1 -> bit_cnt=0. Then send 4'h9
//     -> dout=4'h9 with no remnant bits.
//  6. Pull res low after the 3rd bit of a word -> outputs 0 at once. Send
//     4'h6 after release -> dout=4'h6.

Source files
------------

// File: rtl/sipo_jk_deser.sv
// sipo_jk_deser
//   Serial-in parallel-out deserializer. Collects an MSB-first bit stream
//   into WIDTH-bit words, parks each finished word in a holding register and
//   offers it downstream with a valid/ready handshake. A word that finishes
//   while the holding register is still occupied and not being taken is
//   dropped, and the sticky overrun flag is raised.
//
//   Ports
//     clk       rising-edge clock
//     res       asynchronous reset, active-low
//     si        serial data in, MSB first
//     si_en     sample si on this edge
//     flush     drop the partial word, bit count to 0 (wins over si_en)
//     dout      holding register contents
//     dout_vld  holding register holds an unconsumed word
//     dout_rdy  downstream accepts dout when dout_vld & dout_rdy
//     bit_cnt   bits collected in the current partial word
//     ovr       sticky overrun flag
//     ovr_clr   synchronous clear of ovr (a same-edge set wins)

module sipo_jk_ff (
    input  logic clk,
    input  logic res,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk or negedge res) begin
        if (!res) q <= 1'b0;
        else      q <= (j & ~q) | (~k & q);
    end
endmodule

module sipo_jk_deser #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             si,
    input  logic             si_en,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             ovr,
    input  logic             ovr_clr
);
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] cand;
    logic             shift;
    logic             complete;
    logic             hold_free;
    logic             load;

    assign shift     = si_en & ~flush;
    assign complete  = shift & (bit_cnt == CNT_W'(WIDTH - 1));
    assign cand      = {sreg[WIDTH-2:0], si};
    assign sreg_d    = cand;
    // The holding register can take a new word if empty or emptying this edge.
    assign hold_free = ~dout_vld | dout_rdy;
    assign load      = complete & hold_free;

    // State bits are JK flops with J=D, K=~D; gating both with the enable
    // turns into J=K=0, i.e. hold.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        sipo_jk_ff u_sreg (
            .clk (clk),
            .res (res),
            .j   (shift & sreg_d[i]),
            .k   (shift & ~sreg_d[i]),
            .q   (sreg[i])
        );
        sipo_jk_ff u_dout (
            .clk (clk),
            .res (res),
            .j   (load & cand[i]),
            .k   (load & ~cand[i]),
            .q   (dout[i])
        );
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            bit_cnt  <= '0;
            dout_vld <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (flush || complete) bit_cnt <= '0;
            else if (si_en)        bit_cnt <= bit_cnt + CNT_W'(1);

            if (load)                      dout_vld <= 1'b1;
            else if (dout_vld && dout_rdy) dout_vld <= 1'b0;

            if (complete && !hold_free) ovr <= 1'b1;
            else if (ovr_clr)           ovr <= 1'b0;
        end
    end
endmodule
